// File: rtl/serial_word_collector.sv
// Serial word collector: gathers qualified serial bits into WIDTH-bit words,
// buffers finished words in a 2-entry FIFO behind a valid/ready handshake and
// raises a sticky overrun flag when a finished word has to be dropped.
module serial_word_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_valid,
  input  logic                     s_din,
  input  logic                     msb_first,
  input  logic                     clear,
  output logic [WIDTH-1:0]         word_dout,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  // Assembly state
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             dir_q, dir_d;
  logic             dir_eff;
  logic [WIDTH-1:0] shifted;
  logic             push;

  // FIFO state; entry 0 is always the head
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             pop;

  // Shift in accepted bits, latch direction on the first bit, detect completion
  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    dir_d   = dir_q;
    push    = 1'b0;
    // The first bit of a word uses the live msb_first; later bits use the latched copy
    dir_eff = (cnt_q == '0) ? msb_first : dir_q;
    shifted = dir_eff ? {asm_q[WIDTH-2:0], s_din} : {s_din, asm_q[WIDTH-1:1]};
    if (clear) begin
      // A bit arriving with clear is discarded
      cnt_d = '0;
      asm_d = '0;
    end else if (bit_valid) begin
      asm_d = shifted;
      dir_d = dir_eff;
      if (cnt_q == LastCnt) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // FIFO push/pop bookkeeping and overrun flag
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    pop     = (count_q != 2'd0) && word_ready;
    if (pop) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end
    if (push) begin
      // Evaluated after the pop, so a full FIFO being drained still accepts the word
      if (count_d == 2'd2) begin
        ovr_d = 1'b1;
      end else begin
        if (count_d == 2'd0) begin
          mem_d[0] = shifted;
        end else begin
          mem_d[1] = shifted;
        end
        count_d = count_d + 2'd1;
      end
    end
    if (clear) begin
      ovr_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      asm_q    <= '0;
      dir_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      dir_q    <= dir_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // Output drive; an empty FIFO presents zero
  always_comb begin
    word_valid = (count_q != 2'd0);
    word_dout  = word_valid ? mem_q[0] : '0;
    overrun    = ovr_q;
    bit_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Testbench for serial_word_collector (WIDTH=8): table-driven words plus
// hand-written corner sequences, with a scoreboard queue of expected words
// that is drained by a handshake monitor.
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       s_din;
  logic       msb_first;
  logic       clear;
  logic [7:0] word_dout;
  logic       word_valid;
  logic       word_ready;
  logic       overrun;
  logic [2:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_w;

  typedef struct {
    logic [7:0] word;
    logic       msb;
    int         gap_after;
    int         gap_len;
  } vec_t;

  vec_t vecs [6];

  serial_word_collector #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .s_din      (s_din),
    .msb_first  (msb_first),
    .clear      (clear),
    .word_dout  (word_dout),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  // Every accepted word must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h required none", word_dout);
      end else begin
        exp_w = exp_q.pop_front();
        check("word_out", {24'd0, word_dout}, {24'd0, exp_w});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic m);
    bit_valid = 1'b1;
    s_din     = b;
    msb_first = m;
    step();
    bit_valid = 1'b0;
  endtask

  // Bits are ordered by md; msb_first is driven inverted from bit toggle_at on
  task automatic send_word(input logic [7:0] w, input logic md, input int gap_after,
                           input int gap_len, input bit expect_it, input bit ready_last,
                           input int toggle_at);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = md ? w[7-i] : w[i];
      if (i == 7) begin
        if (expect_it) exp_q.push_back(w);
        if (ready_last) word_ready = 1'b1;
      end
      send_bit(b, (i >= toggle_at) ? ~md : md);
      if (gap_after != 0 && i + 1 == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          step();
          check("gap_bit_cnt", {29'd0, bit_cnt}, gap_after);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{word: 8'hB5, msb: 1'b1, gap_after: 4, gap_len: 3};
    vecs[1] = '{word: 8'h00, msb: 1'b0, gap_after: 0, gap_len: 0};
    vecs[2] = '{word: 8'hFF, msb: 1'b1, gap_after: 0, gap_len: 0};
    vecs[3] = '{word: 8'h81, msb: 1'b1, gap_after: 0, gap_len: 0};
    vecs[4] = '{word: 8'h7E, msb: 1'b0, gap_after: 2, gap_len: 5};
    vecs[5] = '{word: 8'h3C, msb: 1'b0, gap_after: 0, gap_len: 0};

    rst        = 1'b0;
    bit_valid  = 1'b1;
    s_din      = 1'b1;
    msb_first  = 1'b0;
    clear      = 1'b0;
    word_ready = 1'b1;

    // Reset holds everything at zero even with clocks and bits present
    #27;
    check("rst_word_valid", {31'd0, word_valid}, 0);
    check("rst_word_dout", {24'd0, word_dout}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_bit_cnt", {29'd0, bit_cnt}, 0);
    bit_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    // LSB-first word; valid for exactly one cycle after the last bit
    send_word(8'hAB, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    check("t1_valid", {31'd0, word_valid}, 1);
    check("t1_dout", {24'd0, word_dout}, 8'hAB);
    check("t1_bit_cnt", {29'd0, bit_cnt}, 0);
    step();
    check("t1_valid_fall", {31'd0, word_valid}, 0);

    // Table: gaps, both directions, back-to-back throughput
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word, vecs[v].msb, vecs[v].gap_after, vecs[v].gap_len, 1'b1, 1'b0, 8);
      check("vec_end_bit_cnt", {29'd0, bit_cnt}, 0);
    end
    step();
    check("vec_drained", {31'd0, word_valid}, 0);

    // Overrun: third word with FIFO full and no pop is dropped
    word_ready = 1'b0;
    send_word(8'h11, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    send_word(8'h22, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    check("t3_no_ovr_yet", {31'd0, overrun}, 0);
    send_word(8'h33, 1'b0, 0, 0, 1'b0, 1'b0, 8);
    check("t3_overrun", {31'd0, overrun}, 1);
    check("t3_valid", {31'd0, word_valid}, 1);
    check("t3_head", {24'd0, word_dout}, 8'h11);
    word_ready = 1'b1;
    step(); step(); step();
    check("t3_valid_fall", {31'd0, word_valid}, 0);
    check("t3_ovr_sticky", {31'd0, overrun}, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3_ovr_cleared", {31'd0, overrun}, 0);

    // Full FIFO with a pop on the completing edge: no overrun, order kept
    word_ready = 1'b0;
    send_word(8'hA1, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    send_word(8'hB2, 1'b1, 0, 0, 1'b1, 1'b0, 8);
    send_word(8'hC3, 1'b0, 0, 0, 1'b1, 1'b1, 8);
    check("t4_no_overrun", {31'd0, overrun}, 0);
    check("t4_head", {24'd0, word_dout}, 8'hB2);
    step(); step(); step();
    check("t4_drained", {31'd0, word_valid}, 0);

    // Asynchronous reset mid-word with a word buffered
    word_ready = 1'b0;
    send_word(8'h77, 1'b0, 0, 0, 1'b0, 1'b0, 8);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    check("t5_pre_bit_cnt", {29'd0, bit_cnt}, 5);
    check("t5_pre_valid", {31'd0, word_valid}, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_bit_cnt", {29'd0, bit_cnt}, 0);
    check("t5_rst_valid", {31'd0, word_valid}, 0);
    check("t5_rst_dout", {24'd0, word_dout}, 0);
    step();
    rst = 1'b1;
    word_ready = 1'b1;
    step();
    send_word(8'h5A, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    check("t5_dout", {24'd0, word_dout}, 8'h5A);
    step();

    // msb_first toggled mid-word is ignored until the next word
    send_word(8'hC6, 1'b0, 0, 0, 1'b1, 1'b0, 1);
    send_word(8'h39, 1'b1, 0, 0, 1'b1, 1'b0, 3);
    step();

    // clear with a valid bit: partial word and overrun flushed, FIFO kept
    word_ready = 1'b0;
    send_word(8'h3C, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    send_word(8'h4D, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    send_word(8'h5E, 1'b0, 0, 0, 1'b0, 1'b0, 8);
    check("t6_overrun", {31'd0, overrun}, 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_pre_bit_cnt", {29'd0, bit_cnt}, 3);
    bit_valid = 1'b1;
    s_din     = 1'b1;
    clear     = 1'b1;
    step();
    bit_valid = 1'b0;
    clear     = 1'b0;
    check("t6_clr_bit_cnt", {29'd0, bit_cnt}, 0);
    check("t6_clr_overrun", {31'd0, overrun}, 0);
    check("t6_clr_valid", {31'd0, word_valid}, 1);
    check("t6_clr_head", {24'd0, word_dout}, 8'h3C);
    word_ready = 1'b1;
    step(); step(); step();
    check("t6_drained", {31'd0, word_valid}, 0);
    send_word(8'h96, 1'b0, 0, 0, 1'b1, 1'b0, 8);
    check("t6_after_clr", {24'd0, word_dout}, 8'h96);
    step(); step(); step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the universal shift register's serial output (s_right_dout in shift-right mode, s_left_dout in shift-left mode).
- Accumulates qualified serial bits into WIDTH-bit words and counts bits per word.
- Buffers completed words in a 2-entry FIFO with a valid/ready output handshake.
- Flags a sticky overrun when a completed word is lost because the FIFO is full.

Parameters:
- WIDTH, 8, word width in bits and bits per word; legal range 2..32.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- bit_valid, input, 1, s_din carries a valid bit this cycle.
- s_din, input, 1, serial data bit from the shift register's serial output.
- msb_first, input, 1, 1 = first bit of the word is its MSB; 0 = first bit is its LSB.
- clear, input, 1, synchronous flush of the partial word and the overrun flag.
- word_dout, output, WIDTH, head-of-FIFO word.
- word_valid, output, 1, FIFO non-empty.
- word_ready, input, 1, consumer accepts word_dout this cycle.
- overrun, output, 1, sticky: a completed word was dropped.
- bit_cnt, output, $clog2(WIDTH), bits collected in the current partial word.

Behaviour:
- Reset (rst=0, asynchronous):
  - word_dout=0, word_valid=0, overrun=0, bit_cnt=0.
  - Assembly register cleared, FIFO emptied, latched direction=0.
  - Outputs hold these values until the first clk edge after rst returns to 1.
- Reset mid-word: the partial word is discarded; the next accepted bit is bit 0 of a new word.
- Direction latching: msb_first is sampled on the bit with bit_cnt==0 and held for the rest of that word. Changes mid-word have no effect until the next word.
- Bit accept: on a clk edge with bit_valid=1:
  - Direction 0 (LSB first): assembly register shifts right and s_din enters the MSB, so after WIDTH bits the first bit sits at bit 0.
  - Direction 1 (MSB first): assembly register shifts left and s_din enters the LSB.
  - bit_cnt increments.
- bit_valid=0: no state change to the assembly register or bit_cnt. Gaps of any length are allowed.
- Word completion: the bit accepted while bit_cnt==WIDTH-1 completes the word.
  - The word, including that final bit, is pushed to the FIFO on the same edge.
  - bit_cnt wraps to 0.
  - The word appears as word_valid=1 / word_dout one cycle after the edge on which its last bit was accepted.
- FIFO:
  - 2 entries, first-in first-out.
  - word_valid = (count != 0). word_dout = head entry, 0 when empty.
  - Pop occurs when word_valid && word_ready.
- Simultaneous push and pop:
  - When empty: push only, since nothing is valid to pop.
  - When count 1: count stays 1 and the head becomes the new word.
  - When count 2: the pop frees a slot and the push is accepted; no overrun.
- Full and no pop at completion: the new word is dropped, FIFO contents are unchanged, and overrun is set to 1 on that edge. It stays 1 until clear or reset.
- clear=1 (synchronous):
  - bit_cnt=0, assembly register=0, overrun=0.
  - The FIFO is not flushed, and the output handshake continues normally.
  - clear has priority over a bit accepted in the same cycle; that bit is discarded.
- Throughput: with a continuously asserted word_ready, one word per WIDTH accepted bits, with no bubbles.

Test Plan (WIDTH=8):
1. Reset, msb_first=0, word_ready=1, feed bits 1,1,0,1,0,1,0,1 on consecutive cycles -> word_dout=8'hAB with word_valid high for exactly 1 cycle, one cycle after the 8th bit; bit_cnt back to 0.
2. msb_first=1, feed 1,0,1,1,0,1,0,1 with 3 idle cycles (bit_valid=0) inserted after bit 4 -> word_dout=8'hB5; bit_cnt holds 4 during the gap.
3. word_ready=0, send words 8'h11, 8'h22, 8'h33 (LSB first) -> word_valid=1, overrun=1 after the third word. Then word_ready=1 -> pops 8'h11 then 8'h22, word_valid falls, 8'h33 never appears.
4. FIFO holding 2 words, word_ready=1 held on the cycle the next word completes -> no overrun; output order is preserved across all three words.
5. Feed 5 bits, then assert rst=0 asynchronously between clk edges -> bit_cnt=0, word_valid=0 immediately. After release, 8 bits of 8'h5A yield exactly 8'h5A.
6. Toggle msb_first mid-word -> the word is assembled in its originally latched direction. Assert clear together with a valid bit -> bit_cnt=0, overrun=0, the FIFO contents are still delivered.
